// File: rtl/sync_fifo_if.sv
// Handshake/data bundle for sync_fifo.
// Optional error-flag signals exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] wr_data;
    logic              wr_enable;
    logic              full;
    logic              almost_full;
    logic              rd_enable;
    logic [DWIDTH-1:0] rd_data;
    logic              empty;
    logic              almost_empty;
    logic [AWIDTH:0]   level;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic              err_clr;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_data, wr_enable, rd_enable, err_clr,
        input  full, almost_full, rd_data, empty, almost_empty, level, overflow, underflow
    );
    modport slave (
        input  wr_data, wr_enable, rd_enable, err_clr,
        output full, almost_full, rd_data, empty, almost_empty, level, overflow, underflow
    );
`else
    modport master (
        output wr_data, wr_enable, rd_enable,
        input  full, almost_full, rd_data, empty, almost_empty, level
    );
    modport slave (
        input  wr_data, wr_enable, rd_enable,
        output full, almost_full, rd_data, empty, almost_empty, level
    );
`endif
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact fill level, almost-full/almost-empty thresholds
// and selectable registered or first-word-fall-through read.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo #(
    parameter int AWIDTH       = 4,
    parameter int DWIDTH       = 16,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 2,
    parameter int FWFT         = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    sync_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** AWIDTH;
    localparam int LW    = AWIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LEVEL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LEVEL);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_q, level_next;
    logic              full_q, afull_q, empty_q, aempty_q;
    logic              wr_acc, rd_acc;

    // Acceptance uses the flags registered at the start of the cycle, so a
    // full FIFO still takes a read and an empty one still takes a write.
    assign wr_acc = bus.wr_enable & ~full_q;
    assign rd_acc = bus.rd_enable & ~empty_q;

    // Next fill level; simultaneous accepted write and read cancel out.
    always_comb begin
        level_next = level_q;
        if (wr_acc && !rd_acc)
            level_next = level_q + LW'(1);
        else if (rd_acc && !wr_acc)
            level_next = level_q - LW'(1);
    end

    // Pointers, level and all status flags, registered from level_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + LW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + LW'(1);
            level_q  <= level_next;
            full_q   <= (level_next == DEPTH_L);
            afull_q  <= (level_next >= AFULL_L);
            empty_q  <= (level_next == '0);
            aempty_q <= (level_next <= AEMPTY_L);
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[AWIDTH-1:0]] <= bus.wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always visible; don't-care while empty.
            assign bus.rd_data = mem[rd_ptr[AWIDTH-1:0]];
        end else begin : g_reg
            logic [DWIDTH-1:0] rd_q;
            // Head word captured on an accepted read, held otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rd_q <= '0;
                else if (rd_acc)
                    rd_q <= mem[rd_ptr[AWIDTH-1:0]];
            end
            assign bus.rd_data = rd_q;
        end
    endgenerate

    assign bus.full         = full_q;
    assign bus.almost_full  = afull_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = aempty_q;
    assign bus.level        = level_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    // Sticky error flags; clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.err_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.wr_enable && full_q)  ovf_q <= 1'b1;
            if (bus.rd_enable && empty_q) unf_q <= 1'b1;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif
endmodule
